// File: rtl/cma_adapt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cma_adapt_ctrl
// Brief    : Adaptation sequencer for the CMA feed-forward equalizer.
//            Walks the equalizer through pipeline fill and then fast,
//            medium and slow step-size gears. Drives the step size and the
//            coefficient update enable. An optional lock detector averages
//            the CMA error magnitude in the final gear.
// Options  : CMA_LOCK_DET_EN - builds the windowed lock detector. When it is
//            undefined, o_locked is the registered "in GEAR2" flag.
// Revision : 1.0 - initial release
// ============================================================================
module cma_adapt_ctrl #(
    parameter int                       FIR_LEN   = 21,
    parameter int                       NB_MU     = 16,
    parameter int                       NB_CNT    = 20,
    parameter int                       GEAR0_LEN = 4096,
    parameter int                       GEAR1_LEN = 8192,
    parameter logic signed [NB_MU-1:0]  MU_G0     = 16'sd128,
    parameter logic signed [NB_MU-1:0]  MU_G1     = 16'sd32,
    parameter logic signed [NB_MU-1:0]  MU_G2     = 16'sd8,
    parameter int                       NB_ERR    = 18,
    parameter int                       LOG2_WIN  = 8,
    parameter logic [NB_ERR-1:0]        LOCK_THR  = 18'd1024,
    parameter int                       LOCK_WINS = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic              i_start,
    input  logic              i_freeze,
    input  logic [NB_ERR-1:0] i_err_mag,
    output logic [NB_MU-1:0]  o_mu,
    output logic              o_adapt_en,
    output logic [2:0]        o_state,
    output logic              o_locked
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_GEAR0 = 3'd2,
        S_GEAR1 = 3'd3,
        S_GEAR2 = 3'd4
    } state_t;

    localparam logic [NB_CNT-1:0] c_fill_last  = NB_CNT'(FIR_LEN - 1);
    localparam logic [NB_CNT-1:0] c_gear0_last = NB_CNT'(GEAR0_LEN - 1);
    localparam logic [NB_CNT-1:0] c_gear1_last = NB_CNT'(GEAR1_LEN - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [NB_CNT-1:0]  r_cnt;
    logic [NB_CNT-1:0]  w_next_cnt;
    logic [NB_MU-1:0]   w_mu;
    logic               w_adapt;
    logic               w_strobe;

    assign w_strobe = i_en & i_valid;
    assign o_state  = r_state;

    // Next state and phase count for an unfrozen cycle without a restart
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_next_cnt = '0;
            end
            S_FILL: begin
                if (w_strobe) begin
                    if (r_cnt == c_fill_last) begin
                        w_next_state = S_GEAR0;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_GEAR0: begin
                if (w_strobe) begin
                    if (r_cnt == c_gear0_last) begin
                        w_next_state = S_GEAR1;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_GEAR1: begin
                if (w_strobe) begin
                    if (r_cnt == c_gear1_last) begin
                        w_next_state = S_GEAR2;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_GEAR2: begin
                // Terminal gear: the count saturates instead of wrapping
                if (w_strobe && (r_cnt != '1)) begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Step size and update enable decoded from the state being entered
    always_comb begin
        w_mu    = '0;
        w_adapt = 1'b0;
        case (w_next_state)
            S_GEAR0: begin w_mu = MU_G0; w_adapt = 1'b1; end
            S_GEAR1: begin w_mu = MU_G1; w_adapt = 1'b1; end
            S_GEAR2: begin w_mu = MU_G2; w_adapt = 1'b1; end
            default: begin w_mu = '0;    w_adapt = 1'b0; end
        endcase
    end

    // Sequencer registers: reset > start > freeze > strobe, all stalled by !i_en
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            o_mu       <= '0;
            o_adapt_en <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                r_state    <= S_FILL;
                r_cnt      <= '0;
                o_mu       <= '0;
                o_adapt_en <= 1'b0;
            end else if (i_freeze) begin
                o_mu       <= '0;
                o_adapt_en <= 1'b0;
            end else begin
                r_state    <= w_next_state;
                r_cnt      <= w_next_cnt;
                o_mu       <= w_mu;
                o_adapt_en <= w_adapt;
            end
        end
    end

`ifdef CMA_LOCK_DET_EN
    localparam int c_acc_w  = NB_ERR + LOG2_WIN;
    localparam int c_good_w = $clog2(LOCK_WINS + 1);
    localparam logic [c_good_w-1:0] c_lock_wins = c_good_w'(LOCK_WINS);

    logic [c_acc_w-1:0]  r_acc;
    logic [c_acc_w-1:0]  w_acc_sum;
    logic [LOG2_WIN-1:0] r_win;
    logic [c_good_w-1:0] r_good;
    logic                w_win_last;
    logic                w_win_good;

    // The sum of a full window of maximum errors still fits c_acc_w bits
    assign w_acc_sum  = r_acc + c_acc_w'(i_err_mag);
    assign w_win_last = (r_win == '1);
    assign w_win_good = ((w_acc_sum >> LOG2_WIN) < c_acc_w'(LOCK_THR));

    // Windowed average of the error magnitude; lock after enough good windows
    always_ff @(posedge i_clock) begin
        if (i_reset || (i_en && i_start)) begin
            r_acc    <= '0;
            r_win    <= '0;
            r_good   <= '0;
            o_locked <= 1'b0;
        end else if (i_en && !i_freeze) begin
            if (r_state != S_GEAR2) begin
                r_acc    <= '0;
                r_win    <= '0;
                r_good   <= '0;
                o_locked <= 1'b0;
            end else begin
                o_locked <= (r_good == c_lock_wins);
                if (w_strobe) begin
                    if (w_win_last) begin
                        r_acc <= '0;
                        r_win <= '0;
                        if (w_win_good) begin
                            if (r_good != c_lock_wins) begin
                                r_good <= r_good + 1'b1;
                            end
                        end else begin
                            r_good   <= '0;
                            o_locked <= 1'b0;
                        end
                    end else begin
                        r_acc <= w_acc_sum;
                        r_win <= r_win + 1'b1;
                    end
                end
            end
        end
    end
`else
    logic w_unused_lock;

    // Error input and lock parameters only matter when the detector is built
    assign w_unused_lock = (^i_err_mag) ^ (^LOCK_THR) ^ ((LOCK_WINS + LOG2_WIN) != 0);

    // Lock flag simply reports that the final gear has been reached
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_locked <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                o_locked <= 1'b0;
            end else if (!i_freeze) begin
                o_locked <= (w_next_state == S_GEAR2);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/cma_adapt_ctrl.md
# cma_adapt_ctrl

Adaptation sequencer for the CMA feed-forward equalizer. It counts input sample strobes and walks the equalizer through pipeline fill, then fast, medium and slow step-size gears. It drives the step size `i_mu` and the adaptation enable of the FIR/CMA `top`. An optional lock detector watches the CMA error magnitude during the final gear and raises a lock flag.

## Interface
Parameters:
- `FIR_LEN`, 21: equalizer taps; the fill phase lasts `FIR_LEN` strobes.
- `NB_MU`, 16: step-size width, signed.
- `NB_CNT`, 20: phase counter width.
- `GEAR0_LEN`, 4096: strobes spent in gear 0. Must be ≥1.
- `GEAR1_LEN`, 8192: strobes spent in gear 1. Must be ≥1.
- `MU_G0`, 16'sd128: step size in gear 0.
- `MU_G1`, 16'sd32: step size in gear 1.
- `MU_G2`, 16'sd8: step size in gear 2.
- `NB_ERR`, 18: error magnitude width, unsigned.
- `LOG2_WIN`, 8: lock averaging window is 2^LOG2_WIN strobes.
- `LOCK_THR`, 18'd1024: average-error threshold.
- `LOCK_WINS`, 4: consecutive good windows needed for lock.

Ports:
- `i_clock` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_en` in 1: global enable.
- `i_valid` in 1: sample valid. A strobe is `i_en && i_valid`.
- `i_start` in 1: one-cycle pulse that (re)starts adaptation.
- `i_freeze` in 1: holds the coefficients and the sequencer while high.
- `i_err_mag` in `NB_ERR`: CMA error magnitude for the current strobe.
- `o_mu` out `NB_MU`: step size to the equalizer.
- `o_adapt_en` out 1: coefficient update enable.
- `o_state` out 3: current state encoding.
- `o_locked` out 1: lock flag.

## Operation
- States and encodings: IDLE=0, FILL=1, GEAR0=2, GEAR1=3, GEAR2=4. Other codes are unreachable and return to IDLE.
- The phase counter `cnt` advances only on a strobe while `i_freeze`=0. It clears on every state change.
- Transitions, all evaluated on the clock edge:
  - IDLE→FILL on `i_start`. No strobe is needed.
  - FILL→GEAR0 on a strobe with `cnt==FIR_LEN-1`.
  - GEAR0→GEAR1 on a strobe with `cnt==GEAR0_LEN-1`.
  - GEAR1→GEAR2 on a strobe with `cnt==GEAR1_LEN-1`.
  - GEAR2 is terminal. Its counter saturates and does not wrap.
- `i_start` in any non-IDLE state goes to FILL with `cnt`=0. It also clears lock state.
- Outputs per state:
  - IDLE and FILL: `o_mu`=0, `o_adapt_en`=0.
  - GEARk: `o_mu`=MU_Gk, `o_adapt_en`=1.
- Freeze: while `i_freeze`=1, `o_adapt_en`=0 and `o_mu`=0.
  - The state, counter and lock accumulator hold.
  - Freeze overrides a terminal-count strobe in the same cycle, so no transition occurs.
- Priority: `i_reset` > `i_start` > `i_freeze` > strobe.
- Deasserting `i_en` stalls everything without changing any output.

## Timing
- All outputs are registered. `o_state`, `o_mu` and `o_adapt_en` reflect a transition one cycle after the triggering edge.
- `i_freeze` takes effect on `o_adapt_en` and `o_mu` one cycle after it asserts. They resume one cycle after it deasserts.
- Reset values: state IDLE, `cnt`=0, `o_mu`=0, `o_adapt_en`=0, `o_state`=0, `o_locked`=0, accumulator=0, good-window count=0.
- Reset asserted mid-gear returns to IDLE at the next edge. The block then waits for `i_start`.
- Reset and `i_start` in the same cycle leave the block in IDLE.
- Lock arithmetic:
  - Accumulator width is `NB_ERR+LOG2_WIN`, with no overflow possible.
  - Window average is `acc>>LOG2_WIN`, truncated.
  - The comparison is strictly less than `LOCK_THR`, unsigned.

## Configuration
- Macro: `CMA_LOCK_DET_EN`.
- Defined:
  - In GEAR2, each unfrozen strobe adds `i_err_mag` to the accumulator and advances a window counter.
  - The window closes on the 2^LOG2_WIN-th sample. The average is compared and the accumulator clears.
  - A good window increments the good-window count, saturating at `LOCK_WINS`. `o_locked` sets on the edge after the count reaches `LOCK_WINS`.
  - A bad window clears the count and `o_locked` on the next edge.
  - Outside GEAR2 the detector is cleared.
- Undefined:
  - No accumulator logic is built and `i_err_mag` is ignored.
  - `o_locked` is registered `(state==GEAR2)`.

## Test plan
Bench parameters: `FIR_LEN`=21, `GEAR0_LEN`=4, `GEAR1_LEN`=6, `LOG2_WIN`=2, `LOCK_WINS`=2, `LOCK_THR`=100.

- Reset, `i_start`, continuous strobes → `o_state` steps 1, 2, 3, 4 after strobes 21, 25 and 31. `o_mu` steps 0, 128, 32, 8. `o_adapt_en` rises with GEAR0.
- In GEAR1 at `cnt`=5, assert `i_freeze` for 10 strobes → state stays 3, `o_mu`=0, `o_adapt_en`=0. After release, GEAR2 follows on the first strobe.
- In GEAR0, pulse `i_start` → `o_state`=1, `o_mu`=0. The full 21-strobe fill repeats.
- With `CMA_LOCK_DET_EN`, in GEAR2 drive `i_err_mag`=50 → `o_locked`=1 after 8 strobes plus 1 cycle. Then drive 200 for 4 strobes → `o_locked`=0.
- Drop `i_valid` for 5 cycles mid-FILL → counter holds and the GEAR0 entry is delayed by exactly 5 cycles.
- Assert `i_reset` in GEAR2 → next edge all outputs 0. The block stays in IDLE until `i_start`.
